// File: rtl/dvfs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dvfs_pkg
// Purpose  : Shared types, state encoding and helpers for the DVFS
//            transition sequencer and its handshake channels.
// Revision : 1.0 - initial release
// ============================================================================
package dvfs_pkg;

  // Default width of voltage/frequency level codes.
  localparam int LVL_W = 3;

  // Level code type at the default width.
  typedef logic [LVL_W-1:0] lvl_t;

  // Sequencer states. Voltage rises before the frequency step and falls after it.
  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_V_UP        = 3'd1,
    ST_V_UP_SETTLE = 3'd2,
    ST_F_CHG       = 3'd3,
    ST_F_SETTLE    = 3'd4,
    ST_V_DN        = 3'd5,
    ST_V_DN_SETTLE = 3'd6
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dvfs_handshake_ch.sv
`default_nettype none
// ============================================================================
// Module   : dvfs_handshake_ch
// Purpose  : One four-phase req/ack channel (regulator or PLL). Holds the
//            level code stable while req is high, records the acknowledged
//            level and abandons the request after TIMEOUT_CYCLES cycles.
// Revision : 1.0 - initial release
// ============================================================================
module dvfs_handshake_ch #(
  parameter int LVL_W          = dvfs_pkg::LVL_W,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LVL_W-1:0] start_level,
  input  logic             ack,
  output logic [LVL_W-1:0] level,
  output logic             req,
  output logic [LVL_W-1:0] applied,
  output logic             done,
  output logic             timeout
);
  import dvfs_pkg::*;

  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  // Cycles req has been waiting, counted from 0 on the cycle req rises.
  logic [TMO_W-1:0] wait_cnt;

  // Completion and give-up conditions are seen by the sequencer on the same
  // edge that drops req, so the FSM advances in step with the channel.
  assign done    = req & ack;
  assign timeout = req & ~ack & (wait_cnt == TMO_LAST);

  // Request state: level and req rise together, req drops on ack or timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level    <= '0;
      req      <= 1'b0;
      applied  <= '0;
      wait_cnt <= '0;
    end else if (start && !req) begin
      level    <= start_level;
      req      <= 1'b1;
      wait_cnt <= '0;
    end else if (done) begin
      req      <= 1'b0;
      applied  <= level;
    end else if (timeout) begin
      req      <= 1'b0;
    end else if (req) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dvfs_transition_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dvfs_transition_sequencer
// Purpose  : Applies requested voltage/frequency levels to the regulator and
//            PLL, raising voltage before a frequency change and lowering it
//            after, with settle waits, PE clock hold and timeout reporting.
// Revision : 1.0 - initial release
// ============================================================================
module dvfs_transition_sequencer #(
  parameter int LVL_W              = dvfs_pkg::LVL_W,
  parameter int NUM_VOLTAGE_LEVELS = 8,
  parameter int NUM_FREQ_LEVELS    = 8,
  parameter int TIMEOUT_CYCLES     = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LVL_W-1:0] voltage_setting,
  input  logic [LVL_W-1:0] frequency_setting,
  input  logic [7:0]       settle_cycles_cfg,
  output logic [LVL_W-1:0] vr_level,
  output logic             vr_req,
  input  logic             vr_ack,
  output logic [LVL_W-1:0] pll_level,
  output logic             pll_req,
  input  logic             pll_lock,
  output logic             pe_clk_hold,
  output logic             busy,
  output logic [LVL_W-1:0] applied_voltage,
  output logic [LVL_W-1:0] applied_frequency,
  output logic             err_timeout,
  input  logic             err_clear,
  output logic [15:0]      transition_count
);
  import dvfs_pkg::*;

  // Out-of-range requests saturate to the highest legal level.
  function automatic logic [LVL_W-1:0] clamp_lvl(input logic [LVL_W-1:0] value, input int num);
    if (int'(value) >= num) return LVL_W'(num - 1);
    return value;
  endfunction

  state_t           state;
  state_t           next_state;
  logic [LVL_W-1:0] v_in;
  logic [LVL_W-1:0] f_in;
  logic [LVL_W-1:0] v_target;
  logic [LVL_W-1:0] f_target;
  logic [LVL_W-1:0] v_goal;
  logic [LVL_W-1:0] f_goal;
  logic [7:0]       settle_cnt;
  logic             mismatch;
  logic             settle_done_v;
  logic             settle_done_f;
  logic             enter_settle;
  logic             in_settle;
  logic             any_timeout;
  logic             vr_start;
  logic             pll_start;
  logic             vr_done;
  logic             vr_timeout;
  logic             pll_done;
  logic             pll_timeout;
  logic             busy_next;
  logic             hold_next;

  assign v_in     = clamp_lvl(voltage_setting, NUM_VOLTAGE_LEVELS);
  assign f_in     = clamp_lvl(frequency_setting, NUM_FREQ_LEVELS);
  assign mismatch = (v_in != applied_voltage) || (f_in != applied_frequency);

  // Targets come straight from the inputs on the start edge, from the latched
  // copies afterwards, so later input changes cannot disturb a transition.
  assign v_goal = (state == ST_IDLE) ? v_in : v_target;
  assign f_goal = (state == ST_IDLE) ? f_in : f_target;

  // A settle period lasts at least one cycle and ends once the count has
  // run down and the rail has dropped its ack.
  assign settle_done_v = (settle_cnt <= 8'd1) && !vr_ack;
  assign settle_done_f = (settle_cnt <= 8'd1) && !pll_lock;
  assign in_settle     = (state == ST_V_UP_SETTLE) || (state == ST_F_SETTLE) ||
                         (state == ST_V_DN_SETTLE);
  assign enter_settle  = (next_state != state) &&
                         ((next_state == ST_V_UP_SETTLE) || (next_state == ST_F_SETTLE) ||
                          (next_state == ST_V_DN_SETTLE));
  assign any_timeout   = vr_timeout | pll_timeout;

  dvfs_handshake_ch #(
    .LVL_W          (LVL_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_vr_ch (
    .clk         (clk),
    .reset       (reset),
    .start       (vr_start),
    .start_level (v_goal),
    .ack         (vr_ack),
    .level       (vr_level),
    .req         (vr_req),
    .applied     (applied_voltage),
    .done        (vr_done),
    .timeout     (vr_timeout)
  );

  dvfs_handshake_ch #(
    .LVL_W          (LVL_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_pll_ch (
    .clk         (clk),
    .reset       (reset),
    .start       (pll_start),
    .start_level (f_goal),
    .ack         (pll_lock),
    .level       (pll_level),
    .req         (pll_req),
    .applied     (applied_frequency),
    .done        (pll_done),
    .timeout     (pll_timeout)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Sequencing: voltage up, then frequency, then voltage down; any timeout aborts.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (mismatch && !err_timeout) begin
          if (v_in > applied_voltage)         next_state = ST_V_UP;
          else if (f_in != applied_frequency) next_state = ST_F_CHG;
          else                                next_state = ST_V_DN;
        end
      end
      ST_V_UP: begin
        if (vr_done)         next_state = ST_V_UP_SETTLE;
        else if (vr_timeout) next_state = ST_IDLE;
      end
      ST_V_UP_SETTLE: begin
        if (settle_done_v) begin
          if (f_target != applied_frequency)   next_state = ST_F_CHG;
          else if (v_target < applied_voltage) next_state = ST_V_DN;
          else                                 next_state = ST_IDLE;
        end
      end
      ST_F_CHG: begin
        if (pll_done)         next_state = ST_F_SETTLE;
        else if (pll_timeout) next_state = ST_IDLE;
      end
      ST_F_SETTLE: begin
        if (settle_done_f) begin
          if (v_target < applied_voltage) next_state = ST_V_DN;
          else                            next_state = ST_IDLE;
        end
      end
      ST_V_DN: begin
        if (vr_done)         next_state = ST_V_DN_SETTLE;
        else if (vr_timeout) next_state = ST_IDLE;
      end
      ST_V_DN_SETTLE: begin
        if (settle_done_v) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Output decode: channel starts on handshake-state entry, next-cycle busy/hold.
  always_comb begin
    vr_start  = 1'b0;
    pll_start = 1'b0;
    busy_next = (next_state != ST_IDLE);
    hold_next = (next_state == ST_F_CHG) || (next_state == ST_F_SETTLE);
    if (next_state != state) begin
      vr_start  = (next_state == ST_V_UP) || (next_state == ST_V_DN);
      pll_start = (next_state == ST_F_CHG);
    end
  end

  // Registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy        <= 1'b0;
      pe_clk_hold <= 1'b0;
    end else begin
      busy        <= busy_next;
      pe_clk_hold <= hold_next;
    end
  end

  // Latch the targets as a transition leaves IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_target <= '0;
      f_target <= '0;
    end else if ((state == ST_IDLE) && (next_state != ST_IDLE)) begin
      v_target <= v_in;
      f_target <= f_in;
    end
  end

  // Settle counter: loaded on entry to a settle state, counts down to one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      settle_cnt <= 8'd0;
    end else if (enter_settle) begin
      settle_cnt <= settle_cycles_cfg;
    end else if (in_settle && (settle_cnt > 8'd1)) begin
      settle_cnt <= settle_cnt - 8'd1;
    end
  end

  // Sticky timeout flag; a new timeout outranks a simultaneous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           err_timeout <= 1'b0;
    else if (any_timeout) err_timeout <= 1'b1;
    else if (err_clear)   err_timeout <= 1'b0;
  end

  // Count transitions that return to IDLE without a timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      transition_count <= 16'd0;
    end else if ((state != ST_IDLE) && (next_state == ST_IDLE) && !any_timeout) begin
      transition_count <= sat_inc16(transition_count);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dvfs_transition_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dvfs_transition_sequencer
// Purpose  : Directed self-checking bench for the DVFS transition sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dvfs_transition_sequencer;

  localparam int LVL_W = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [LVL_W-1:0] voltage_setting = '0;
  logic [LVL_W-1:0] frequency_setting = '0;
  logic [7:0]       settle_cycles_cfg = 8'd0;
  logic             vr_ack = 1'b0;
  logic             pll_lock = 1'b0;
  logic             err_clear = 1'b0;
  logic [LVL_W-1:0] vr_level;
  logic             vr_req;
  logic [LVL_W-1:0] pll_level;
  logic             pll_req;
  logic             pe_clk_hold;
  logic             busy;
  logic [LVL_W-1:0] applied_voltage;
  logic [LVL_W-1:0] applied_frequency;
  logic             err_timeout;
  logic [15:0]      transition_count;

  int tests_run = 0;
  int tests_failed = 0;

  // Responder settings
  int vr_delay = 3;
  int pll_delay = 3;
  bit vr_stuck = 1'b0;
  int vr_n = 0;
  int pll_n = 0;

  // Monitor counters
  int cyc = 0;
  int vr_rises = 0, pll_rises = 0, vr_high = 0, hold_cyc = 0, settle_cyc = 0, hold_bad = 0;
  int vr_rise_cyc = 0, vr_fall_cyc = 0, pll_rise_cyc = 0, pll_fall_cyc = 0;
  bit prev_vr = 1'b0, prev_pll = 1'b0;

  dvfs_transition_sequencer #(
    .LVL_W              (LVL_W),
    .NUM_VOLTAGE_LEVELS (8),
    .NUM_FREQ_LEVELS    (8),
    .TIMEOUT_CYCLES     (64)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .voltage_setting   (voltage_setting),
    .frequency_setting (frequency_setting),
    .settle_cycles_cfg (settle_cycles_cfg),
    .vr_level          (vr_level),
    .vr_req            (vr_req),
    .vr_ack            (vr_ack),
    .pll_level         (pll_level),
    .pll_req           (pll_req),
    .pll_lock          (pll_lock),
    .pe_clk_hold       (pe_clk_hold),
    .busy              (busy),
    .applied_voltage   (applied_voltage),
    .applied_frequency (applied_frequency),
    .err_timeout       (err_timeout),
    .err_clear         (err_clear),
    .transition_count  (transition_count)
  );

  always #5 clk = ~clk;

  // Regulator model: ack after vr_delay cycles of req, drops once req is gone.
  initial begin
    forever begin
      @(negedge clk);
      if (vr_req && !vr_stuck) begin
        vr_n = vr_n + 1;
        if (vr_n >= vr_delay) vr_ack = 1'b1;
      end else begin
        vr_n = 0;
        vr_ack = 1'b0;
      end
    end
  end

  // PLL model: lock after pll_delay cycles of req.
  initial begin
    forever begin
      @(negedge clk);
      if (pll_req) begin
        pll_n = pll_n + 1;
        if (pll_n >= pll_delay) pll_lock = 1'b1;
      end else begin
        pll_n = 0;
        pll_lock = 1'b0;
      end
    end
  end

  // Handshake/hold observer sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc = cyc + 1;
      if (vr_req && !prev_vr) begin vr_rises = vr_rises + 1; vr_rise_cyc = cyc; end
      if (!vr_req && prev_vr) vr_fall_cyc = cyc;
      if (pll_req && !prev_pll) begin pll_rises = pll_rises + 1; pll_rise_cyc = cyc; end
      if (!pll_req && prev_pll) pll_fall_cyc = cyc;
      if (vr_req) vr_high = vr_high + 1;
      if (pe_clk_hold) hold_cyc = hold_cyc + 1;
      if (busy && !vr_req && !pll_req) settle_cyc = settle_cyc + 1;
      if ((pe_clk_hold && vr_req) || (pll_req && !pe_clk_hold) || (pe_clk_hold && !busy))
        hold_bad = hold_bad + 1;
      prev_vr = vr_req;
      prev_pll = pll_req;
    end
  end

  // Global safety net
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests_run=%0d", tests_run);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Waits for a transition to finish; bc = busy cycles observed.
  task automatic wait_done(input int budget, input string name, output int bc);
    bc = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (busy) bc = bc + 1;
      else if (bc > 0) return;
    end
    tests_run = tests_run + 1;
    tests_failed = tests_failed + 1;
    $display("FAIL %s: transition not finished in %0d cycles (busy cycles %0d)", name, budget, bc);
  endtask

  task automatic wait_pll_req(input string name);
    for (int i = 0; i < 30; i++) begin
      if (pll_req) return;
      tick();
    end
    tests_run = tests_run + 1;
    tests_failed = tests_failed + 1;
    $display("FAIL %s: pll_req never rose", name);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    tests_run = tests_run + 1;
    if ({vr_req, pll_req, pe_clk_hold, busy, err_timeout} !== 5'b0) begin
      tests_failed = tests_failed + 1;
      $display("FAIL reset_flags: got %b want 00000", {vr_req, pll_req, pe_clk_hold, busy, err_timeout});
    end
    tests_run = tests_run + 1;
    if ({vr_level, pll_level, applied_voltage, applied_frequency} !== 12'd0) begin
      tests_failed = tests_failed + 1;
      $display("FAIL reset_levels: got %h want 000", {vr_level, pll_level, applied_voltage, applied_frequency});
    end
    tests_run = tests_run + 1;
    if (transition_count !== 16'd0) begin
      tests_failed = tests_failed + 1;
      $display("FAIL reset_count: got %0d want 0", transition_count);
    end
    reset = 1'b1;
    repeat (3) tick();
    tests_run = tests_run + 1;
    if (busy !== 1'b0 || vr_req !== 1'b0) begin
      tests_failed = tests_failed + 1;
      $display("FAIL idle_no_mismatch: busy=%b vr_req=%b want 0 0", busy, vr_req);
    end
  endtask

  task automatic test_up_shift();
    int bc, r_vr, r_pll, r_vh, r_hb, r_hold;
    r_vr = vr_rises; r_pll = pll_rises; r_vh = vr_high; r_hb = hold_bad; r_hold = hold_cyc;
    voltage_setting = 3'd5; frequency_setting = 3'd5;
    tick();
    tests_run = tests_run + 1;
    if (busy !== 1'b1 || vr_req !== 1'b1 || vr_level !== 3'd5) begin
      tests_failed = tests_failed + 1;
      $display("FAIL up_start_latency: busy=%b vr_req=%b vr_level=%0d want 1 1 5", busy, vr_req, vr_level);
    end
    wait_done(40, "up_shift", bc);
    tests_run = tests_run + 1;
    if (bc + 1 !== 8) begin
      tests_failed = tests_failed + 1;
      $display("FAIL up_busy_cycles: got %0d want 8", bc + 1);
    end
    tests_run = tests_run + 1;
    if (applied_voltage !== 3'd5 || applied_frequency !== 3'd5 || transition_count !== 16'd1) begin
      tests_failed = tests_failed + 1;
      $display("FAIL up_result: got V=%0d F=%0d cnt=%0d want 5 5 1", applied_voltage, applied_frequency, transition_count);
    end
    tests_run = tests_run + 1;
    if (pll_rise_cyc !== vr_fall_cyc + 1 || vr_rises - r_vr !== 1 || pll_rises - r_pll !== 1) begin
      tests_failed = tests_failed + 1;
      $display("FAIL up_order: vr_fall=%0d pll_rise=%0d vr_rises=%0d pll_rises=%0d want pll_rise=vr_fall+1, 1, 1",
               vr_fall_cyc, pll_rise_cyc, vr_rises - r_vr, pll_rises - r_pll);
    end
    tests_run = tests_run + 1;
    if (vr_high - r_vh !== 3 || hold_cyc - r_hold !== 4 || hold_bad !== r_hb) begin
      tests_failed = tests_failed + 1;
      $display("FAIL up_hold: vr_high=%0d hold=%0d hold_bad=%0d want 3 4 0",
               vr_high - r_vh, hold_cyc - r_hold, hold_bad - r_hb);
    end
  endtask

  task automatic test_down_shift();
    int bc, r_hb, r_hold;
    r_hb = hold_bad; r_hold = hold_cyc;
    voltage_setting = 3'd2; frequency_setting = 3'd2;
    tick();
    tests_run = tests_run + 1;
    if (pll_req !== 1'b1 || vr_req !== 1'b0 || pe_clk_hold !== 1'b1 || pll_level !== 3'd2) begin
      tests_failed = tests_failed + 1;
      $display("FAIL down_first_step: pll_req=%b vr_req=%b hold=%b pll_level=%0d want 1 0 1 2",
               pll_req, vr_req, pe_clk_hold, pll_level);
    end
    wait_done(40, "down_shift", bc);
    tests_run = tests_run + 1;
    if (bc + 1 !== 8 || vr_rise_cyc !== pll_fall_cyc + 1) begin
      tests_failed = tests_failed + 1;
      $display("FAIL down_order: busy=%0d pll_fall=%0d vr_rise=%0d want 8 and vr_rise=pll_fall+1",
               bc + 1, pll_fall_cyc, vr_rise_cyc);
    end
    tests_run = tests_run + 1;
    if (hold_cyc - r_hold !== 4 || hold_bad !== r_hb) begin
      tests_failed = tests_failed + 1;
      $display("FAIL down_hold: hold=%0d hold_bad=%0d want 4 0", hold_cyc - r_hold, hold_bad - r_hb);
    end
    tests_run = tests_run + 1;
    if (applied_voltage !== 3'd2 || applied_frequency !== 3'd2 || transition_count !== 16'd2) begin
      tests_failed = tests_failed + 1;
      $display("FAIL down_result: got V=%0d F=%0d cnt=%0d want 2 2 2", applied_voltage, applied_frequency, transition_count);
    end
  endtask

  task automatic test_freq_only();
    int bc, r_vr, r_pll, r_set, r_hold;
    voltage_setting = 3'd3; frequency_setting = 3'd3;
    wait_done(40, "to_3_3", bc);
    settle_cycles_cfg = 8'd4;
    r_vr = vr_rises; r_pll = pll_rises; r_set = settle_cyc; r_hold = hold_cyc;
    frequency_setting = 3'd6;
    wait_done(40, "freq_only", bc);
    tests_run = tests_run + 1;
    if (vr_rises - r_vr !== 0 || pll_rises - r_pll !== 1) begin
      tests_failed = tests_failed + 1;
      $display("FAIL freq_only_handshakes: vr=%0d pll=%0d want 0 1", vr_rises - r_vr, pll_rises - r_pll);
    end
    tests_run = tests_run + 1;
    if (bc !== 7 || settle_cyc - r_set !== 4 || hold_cyc - r_hold !== 7) begin
      tests_failed = tests_failed + 1;
      $display("FAIL freq_only_settle: busy=%0d settle=%0d hold=%0d want 7 4 7",
               bc, settle_cyc - r_set, hold_cyc - r_hold);
    end
    tests_run = tests_run + 1;
    if (applied_voltage !== 3'd3 || applied_frequency !== 3'd6 || transition_count !== 16'd4) begin
      tests_failed = tests_failed + 1;
      $display("FAIL freq_only_result: got V=%0d F=%0d cnt=%0d want 3 6 4", applied_voltage, applied_frequency, transition_count);
    end
    settle_cycles_cfg = 8'd0;
  endtask

  task automatic test_timeout();
    int bc, r_vh, r_pll, idle_busy, r_vr;
    r_vh = vr_high; r_pll = pll_rises;
    vr_stuck = 1'b1;
    voltage_setting = 3'd4;
    wait_done(100, "timeout", bc);
    tests_run = tests_run + 1;
    if (bc !== 64 || vr_high - r_vh !== 64 || pll_rises - r_pll !== 0) begin
      tests_failed = tests_failed + 1;
      $display("FAIL timeout_length: busy=%0d vr_high=%0d pll_rises=%0d want 64 64 0", bc, vr_high - r_vh, pll_rises - r_pll);
    end
    tests_run = tests_run + 1;
    if (err_timeout !== 1'b1 || applied_voltage !== 3'd3 || applied_frequency !== 3'd6 || transition_count !== 16'd4) begin
      tests_failed = tests_failed + 1;
      $display("FAIL timeout_state: err=%b V=%0d F=%0d cnt=%0d want 1 3 6 4",
               err_timeout, applied_voltage, applied_frequency, transition_count);
    end
    voltage_setting = 3'd5; frequency_setting = 3'd1;
    r_vr = vr_rises;
    idle_busy = 0;
    repeat (6) begin
      tick();
      if (busy) idle_busy = idle_busy + 1;
    end
    tests_run = tests_run + 1;
    if (idle_busy !== 0 || vr_rises !== r_vr || err_timeout !== 1'b1) begin
      tests_failed = tests_failed + 1;
      $display("FAIL timeout_blocks_start: busy=%0d vr_rises=%0d err=%b want 0 0 1", idle_busy, vr_rises - r_vr, err_timeout);
    end
    vr_stuck = 1'b0;
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    tests_run = tests_run + 1;
    if (err_timeout !== 1'b0) begin
      tests_failed = tests_failed + 1;
      $display("FAIL err_clear: err=%b want 0", err_timeout);
    end
    wait_done(40, "after_clear", bc);
    tests_run = tests_run + 1;
    if (bc !== 8 || applied_voltage !== 3'd5 || applied_frequency !== 3'd1 || transition_count !== 16'd5) begin
      tests_failed = tests_failed + 1;
      $display("FAIL after_clear_result: busy=%0d V=%0d F=%0d cnt=%0d want 8 5 1 5",
               bc, applied_voltage, applied_frequency, transition_count);
    end
  endtask

  task automatic test_back_to_back();
    int bc;
    reset = 1'b0;
    voltage_setting = 3'd0; frequency_setting = 3'd0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    voltage_setting = 3'd7; frequency_setting = 3'd7;
    tick();
    wait_pll_req("mid_change");
    voltage_setting = 3'd1; frequency_setting = 3'd1;
    wait_done(40, "mid_first", bc);
    tests_run = tests_run + 1;
    if (applied_voltage !== 3'd7 || applied_frequency !== 3'd7 || transition_count !== 16'd1) begin
      tests_failed = tests_failed + 1;
      $display("FAIL mid_first_result: V=%0d F=%0d cnt=%0d want 7 7 1", applied_voltage, applied_frequency, transition_count);
    end
    tick();
    tests_run = tests_run + 1;
    if (busy !== 1'b1 || pll_req !== 1'b1 || pll_level !== 3'd1) begin
      tests_failed = tests_failed + 1;
      $display("FAIL mid_restart: busy=%b pll_req=%b pll_level=%0d want 1 1 1", busy, pll_req, pll_level);
    end
    wait_done(40, "mid_second", bc);
    tests_run = tests_run + 1;
    if (applied_voltage !== 3'd1 || applied_frequency !== 3'd1 || transition_count !== 16'd2) begin
      tests_failed = tests_failed + 1;
      $display("FAIL mid_second_result: V=%0d F=%0d cnt=%0d want 1 1 2", applied_voltage, applied_frequency, transition_count);
    end
  endtask

  task automatic test_reset_mid();
    int bc, r_vr, r_pll;
    voltage_setting = 3'd4; frequency_setting = 3'd4;
    tick();
    wait_pll_req("reset_mid");
    reset = 1'b0;
    #1;
    tests_run = tests_run + 1;
    if ({vr_req, pll_req, pe_clk_hold, busy, err_timeout} !== 5'b0 ||
        {vr_level, pll_level, applied_voltage, applied_frequency} !== 12'd0 || transition_count !== 16'd0) begin
      tests_failed = tests_failed + 1;
      $display("FAIL reset_async: flags=%b levels=%h cnt=%0d want 0 000 0",
               {vr_req, pll_req, pe_clk_hold, busy, err_timeout},
               {vr_level, pll_level, applied_voltage, applied_frequency}, transition_count);
    end
    repeat (2) tick();
    r_vr = vr_rises; r_pll = pll_rises;
    reset = 1'b1;
    wait_done(40, "reset_restart", bc);
    tests_run = tests_run + 1;
    if (vr_rises - r_vr !== 1 || pll_rises - r_pll !== 1 || bc !== 8) begin
      tests_failed = tests_failed + 1;
      $display("FAIL reset_restart_seq: vr=%0d pll=%0d busy=%0d want 1 1 8", vr_rises - r_vr, pll_rises - r_pll, bc);
    end
    tests_run = tests_run + 1;
    if (applied_voltage !== 3'd4 || applied_frequency !== 3'd4 || transition_count !== 16'd1) begin
      tests_failed = tests_failed + 1;
      $display("FAIL reset_restart_result: V=%0d F=%0d cnt=%0d want 4 4 1", applied_voltage, applied_frequency, transition_count);
    end
  endtask

  initial begin
    test_reset();
    test_up_shift();
    test_down_shift();
    test_freq_only();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
